tespar_epoch_extract: RTL and testbench
=======================================

// Module: tespar_epoch_extract
// PURPOSE
//  Upstream stage of the TESPAR coder. Segments a signed sample stream into epochs.
//  An epoch is a run of same-sign samples between real zero crossings.
//  Per closed epoch, emits duration D (sample count) and shape S (count of local minima
//  of |x| inside the epoch), with a one-cycle valid strobe.
//  The outputs drive the D/S/valid inputs of tespar_lookup directly.
// PARAMETERS
//  SAMPLE_W  16  width of two's-complement input sample
//  D_W        6  width of duration output; D saturates at 2**D_W-1 (63)
//  S_W        5  width of shape output; S saturates at 2**S_W-1 (31)
// PORTS
//  clk           in   1         single clock, all logic rising-edge
//  rst           in   1         synchronous, active-high reset
//  sample_i      in   SAMPLE_W  signed input sample
//  sample_vld_i  in   1         sample_i valid this cycle; no backpressure, every valid sample consumed
//  flush_i       in   1         end of stream: close the open epoch now
//  D             out  D_W       duration of closed epoch (registered)
//  S             out  S_W       local-minima count of closed epoch (registered)
//  polarity_o    out  1         1 = positive epoch (x>=0), 0 = negative
//  valid         out  1         one-cycle strobe, D/S/polarity_o valid
// BEHAVIOUR
//  - Reset: D=0, S=0, polarity_o=0, valid=0. FSM goes to IDLE; all counters and flags are cleared.
//    Reset mid-epoch discards the open epoch; nothing is emitted.
//  - Sign: x>=0 counts as positive, so zero belongs to the positive class.
//  - Magnitude: mag = |x|. The most negative code (-2**(SAMPLE_W-1)) saturates to 2**(SAMPLE_W-1)-1.
//  - FSM IDLE: first valid sample opens an epoch (dcnt=1, scnt=0, fall=0, pol=sign, prev=mag) -> RUN.
//  - FSM RUN, valid sample with same sign:
//    - dcnt += 1, saturating at 63.
//    - If mag<prev: fall=1. If mag>prev: when fall=1, scnt += 1 (saturating at 31); then fall=0.
//    - If mag==prev: fall is unchanged, so plateaus count once.
//    - prev=mag.
//  - FSM RUN, valid sample with opposite sign:
//    - Register D=dcnt, S=scnt, polarity_o=pol; valid=1 on the next cycle.
//    - The same sample opens the next epoch (dcnt=1, scnt=0, fall=0). Stay in RUN.
//  - Latency: valid rises exactly 1 cycle after the crossing sample is accepted.
//    Back-to-back crossings give valid on consecutive cycles.
//  - sample_vld_i=0 cycles are gaps: no counting and no state change.
//  - flush_i in RUN:
//    - Emit the open epoch as above (valid next cycle) -> IDLE.
//    - flush_i in IDLE: no effect.
//  - flush_i with sample_vld_i=1 in the same cycle is a protocol error:
//    - The sample is dropped and the flush proceeds.
//  - Minimum at epoch edge: a falling run ended by a crossing is not counted.
//  - valid is low in every cycle not listed above.
// STRUCTURE
//  - tespar_pkg holds:
//    - localparams TESPAR_D_W=6, TESPAR_S_W=5, TESPAR_DMAX=63, TESPAR_SMAX=31
//    - FSM enum typedef {IDLE, RUN}
//  - One sub-module, tespar_min_detect: holds prev/fall registers and the magnitude compare.
//    Inputs: mag, advance, restart. Output: min_pulse (one-cycle local-minimum hit).
//    The top level holds the FSM, counters and output registers.
// TESTING
//  1. +1,+2,+3,-1 (continuous valid) -> valid 1 cycle after -1: D=3, S=0, polarity_o=1.
//  2. +5,+2,+4,+1,+3,-2 -> D=5, S=2, polarity_o=1.
//     -4,-1,-6,+0 -> D=3, S=1, polarity_o=0.
//  3. +5,+2,+2,+4,-1 (plateau) -> D=4, S=1.
//     70 samples of +7 then -7 -> D=63, S=0.
//  4. +3,-3,+3,-3 -> valid strobes on consecutive cycles with D=1, S=0.
//     Then gaps of 3 idle cycles between samples -> identical D/S results.
//  5. +1,+2 then flush_i -> D=2, S=0, valid next cycle, FSM IDLE.
//     A second flush_i -> no valid.
//     -32768,-1,-5,+1 -> D=3, S=1.
//  6. rst asserted after +1,+2,+3 -> no valid emitted.
//     Then +4,-4 -> D=1, S=0.

Source files
------------

// File: rtl/tespar_pkg.sv
// Shared constants and FSM state type for the TESPAR coder front end.
package tespar_pkg;

    localparam int TESPAR_D_W  = 6;
    localparam int TESPAR_S_W  = 5;
    localparam int TESPAR_DMAX = 63;
    localparam int TESPAR_SMAX = 31;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tespar_state_t;

endpackage

// File: rtl/tespar_min_detect.sv
// Tracks the previous magnitude and a falling flag; pulses when a fall is followed by a rise.
module tespar_min_detect
    import tespar_pkg::*;
#(
    parameter int MAG_W = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [MAG_W-1:0] mag_i,
    input  logic             advance_i,
    input  logic             restart_i,
    output logic             min_pulse_o
);

    logic [MAG_W-1:0] prev_q;
    logic             fall_q;

    // Equal magnitudes leave fall_q alone, so a flat-bottomed valley counts once.
    assign min_pulse_o = advance_i && fall_q && (mag_i > prev_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= '0;
            fall_q <= 1'b0;
        end else if (restart_i) begin
            prev_q <= mag_i;
            fall_q <= 1'b0;
        end else if (advance_i) begin
            prev_q <= mag_i;
            if (mag_i < prev_q) begin
                fall_q <= 1'b1;
            end else if (mag_i > prev_q) begin
                fall_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/tespar_epoch_extract.sv
// Splits a signed sample stream into same-sign epochs and emits duration D and
// local-minima count S for each closed epoch with a one-cycle valid strobe.
module tespar_epoch_extract
    import tespar_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int D_W      = TESPAR_D_W,
    parameter int S_W      = TESPAR_S_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [SAMPLE_W-1:0] sample_i,
    input  logic                       sample_vld_i,
    input  logic                       flush_i,
    output logic        [D_W-1:0]      D,
    output logic        [S_W-1:0]      S,
    output logic                       polarity_o,
    output logic                       valid
);

    localparam int MAG_W = SAMPLE_W - 1;

    function automatic logic [MAG_W-1:0] abs_sat(input logic signed [SAMPLE_W-1:0] x);
        logic signed [SAMPLE_W-1:0] n;
        if (!x[SAMPLE_W-1]) begin
            return x[MAG_W-1:0];
        end
        if (x == {1'b1, {MAG_W{1'b0}}}) begin
            return {MAG_W{1'b1}};
        end
        n = -x;
        return n[MAG_W-1:0];
    endfunction

    function automatic logic [D_W-1:0] sat_inc_d(input logic [D_W-1:0] v);
        return (v == {D_W{1'b1}}) ? v : v + D_W'(1);
    endfunction

    function automatic logic [S_W-1:0] sat_inc_s(input logic [S_W-1:0] v);
        return (v == {S_W{1'b1}}) ? v : v + S_W'(1);
    endfunction

    tespar_state_t    state_q;
    logic [D_W-1:0]   dcnt_q;
    logic [S_W-1:0]   scnt_q;
    logic             pol_q;
    logic [D_W-1:0]   d_out_q;
    logic [S_W-1:0]   s_out_q;
    logic             pol_out_q;
    logic             valid_q;

    logic [MAG_W-1:0] mag_d;
    logic             pos_d;
    logic             take_d;
    logic             restart_d;
    logic             advance_d;
    logic             min_pulse_d;

    // A sample arriving together with flush is dropped; the flush wins.
    assign mag_d     = abs_sat(sample_i);
    assign pos_d     = ~sample_i[SAMPLE_W-1];
    assign take_d    = sample_vld_i && !flush_i;
    assign restart_d = take_d && ((state_q == IDLE) || (pos_d != pol_q));
    assign advance_d = take_d && (state_q == RUN) && (pos_d == pol_q);

    tespar_min_detect #(
        .MAG_W (MAG_W)
    ) u_min_detect (
        .clk         (clk),
        .rst         (rst),
        .mag_i       (mag_d),
        .advance_i   (advance_d),
        .restart_i   (restart_d),
        .min_pulse_o (min_pulse_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            dcnt_q    <= '0;
            scnt_q    <= '0;
            pol_q     <= 1'b0;
            d_out_q   <= '0;
            s_out_q   <= '0;
            pol_out_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (take_d) begin
                        dcnt_q  <= D_W'(1);
                        scnt_q  <= '0;
                        pol_q   <= pos_d;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (flush_i) begin
                        d_out_q   <= dcnt_q;
                        s_out_q   <= scnt_q;
                        pol_out_q <= pol_q;
                        valid_q   <= 1'b1;
                        state_q   <= IDLE;
                    end else if (take_d) begin
                        if (pos_d != pol_q) begin
                            d_out_q   <= dcnt_q;
                            s_out_q   <= scnt_q;
                            pol_out_q <= pol_q;
                            valid_q   <= 1'b1;
                            dcnt_q    <= D_W'(1);
                            scnt_q    <= '0;
                            pol_q     <= pos_d;
                        end else begin
                            dcnt_q <= sat_inc_d(dcnt_q);
                            if (min_pulse_d) begin
                                scnt_q <= sat_inc_s(scnt_q);
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign D          = d_out_q;
    assign S          = s_out_q;
    assign polarity_o = pol_out_q;
    assign valid      = valid_q;

endmodule

// File: tb/tb_tespar_epoch_extract.sv
// Directed bench for tespar_epoch_extract with hand-computed epoch results.
module tb_tespar_epoch_extract;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [15:0] sample_i = '0;
    logic               sample_vld_i = 1'b0;
    logic               flush_i = 1'b0;
    logic [5:0]         D;
    logic [4:0]         S;
    logic               polarity_o;
    logic               valid;

    int checks = 0;
    int errors = 0;

    tespar_epoch_extract dut (
        .clk          (clk),
        .rst          (rst),
        .sample_i     (sample_i),
        .sample_vld_i (sample_vld_i),
        .flush_i      (flush_i),
        .D            (D),
        .S            (S),
        .polarity_o   (polarity_o),
        .valid        (valid)
    );

    always #5 clk = ~clk;

    task automatic step(input logic v, input logic signed [15:0] x, input logic f);
        @(negedge clk);
        sample_vld_i = v;
        sample_i     = x;
        flush_i      = f;
        @(posedge clk);
        #1;
        sample_vld_i = 1'b0;
        flush_i      = 1'b0;
    endtask

    task automatic check_emit(input string tag, input int d, input int s, input logic p);
        checks++;
        assert (valid === 1'b1 && D === 6'(d) && S === 5'(s) && polarity_o === p)
        else begin
            errors++;
            $error("FAIL %s: got valid=%0b D=%0d S=%0d pol=%0b, want valid=1 D=%0d S=%0d pol=%0b",
                   tag, valid, D, S, polarity_o, d, s, p);
        end
    endtask

    task automatic check_quiet(input string tag);
        checks++;
        assert (valid === 1'b0)
        else begin
            errors++;
            $error("FAIL %s: got valid=%0b, want valid=0", tag, valid);
        end
    endtask

    task automatic send(input logic signed [15:0] x, input string tag);
        step(1'b1, x, 1'b0);
        check_quiet(tag);
    endtask

    task automatic gap3(input string tag);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 16'sd0, 1'b0);
            check_quiet(tag);
        end
    endtask

    initial begin
        step(1'b0, 16'sd0, 1'b0);
        step(1'b0, 16'sd0, 1'b0);
        checks++;
        assert (valid === 1'b0 && D === 6'd0 && S === 5'd0 && polarity_o === 1'b0)
        else begin
            errors++;
            $error("FAIL reset: got valid=%0b D=%0d S=%0d pol=%0b, want all zero", valid, D, S, polarity_o);
        end
        rst = 1'b0;

        // rising positive run then crossing
        send(16'sd1, "t1_a");
        send(16'sd2, "t1_b");
        send(16'sd3, "t1_c");
        step(1'b1, -16'sd1, 1'b0);  check_emit("t1_emit", 3, 0, 1'b1);
        step(1'b0, 16'sd0, 1'b1);   check_emit("t1_flush", 1, 0, 1'b0);

        // two minima in a positive epoch, one in a negative epoch
        send(16'sd5, "t2_a");
        send(16'sd2, "t2_b");
        send(16'sd4, "t2_c");
        send(16'sd1, "t2_d");
        send(16'sd3, "t2_e");
        step(1'b1, -16'sd2, 1'b0);  check_emit("t2_pos", 5, 2, 1'b1);
        step(1'b0, 16'sd0, 1'b1);   check_emit("t2_flush_a", 1, 0, 1'b0);
        send(-16'sd4, "t2_f");
        send(-16'sd1, "t2_g");
        send(-16'sd6, "t2_h");
        step(1'b1, 16'sd0, 1'b0);   check_emit("t2_neg", 3, 1, 1'b0);
        step(1'b0, 16'sd0, 1'b1);   check_emit("t2_flush_b", 1, 0, 1'b1);

        // plateau counts once; duration saturates
        send(16'sd5, "t3_a");
        send(16'sd2, "t3_b");
        send(16'sd2, "t3_c");
        send(16'sd4, "t3_d");
        step(1'b1, -16'sd1, 1'b0);  check_emit("t3_plateau", 4, 1, 1'b1);
        step(1'b0, 16'sd0, 1'b1);   check_emit("t3_flush_a", 1, 0, 1'b0);
        for (int i = 0; i < 70; i++) step(1'b1, 16'sd7, 1'b0);
        check_quiet("t3_long");
        step(1'b1, -16'sd7, 1'b0);  check_emit("t3_dsat", 63, 0, 1'b1);
        step(1'b0, 16'sd0, 1'b1);   check_emit("t3_flush_b", 1, 0, 1'b0);

        // back-to-back crossings, then the same with idle gaps
        send(16'sd3, "t4_a");
        step(1'b1, -16'sd3, 1'b0);  check_emit("t4_b2b_1", 1, 0, 1'b1);
        step(1'b1, 16'sd3, 1'b0);   check_emit("t4_b2b_2", 1, 0, 1'b0);
        step(1'b1, -16'sd3, 1'b0);  check_emit("t4_b2b_3", 1, 0, 1'b1);
        step(1'b0, 16'sd0, 1'b1);   check_emit("t4_flush_a", 1, 0, 1'b0);
        send(16'sd3, "t4_g0");
        gap3("t4_gap1");
        step(1'b1, -16'sd3, 1'b0);  check_emit("t4_gap_1", 1, 0, 1'b1);
        gap3("t4_gap2");
        step(1'b1, 16'sd3, 1'b0);   check_emit("t4_gap_2", 1, 0, 1'b0);
        gap3("t4_gap3");
        step(1'b1, -16'sd3, 1'b0);  check_emit("t4_gap_3", 1, 0, 1'b1);
        step(1'b0, 16'sd0, 1'b1);   check_emit("t4_flush_b", 1, 0, 1'b0);

        // flush behaviour and most-negative sample
        send(16'sd1, "t5_a");
        send(16'sd2, "t5_b");
        step(1'b0, 16'sd0, 1'b1);   check_emit("t5_flush", 2, 0, 1'b1);
        step(1'b0, 16'sd0, 1'b1);   check_quiet("t5_flush_idle");
        step(1'b1, 16'sd100, 1'b1); check_quiet("t5_flush_with_sample");
        send(-16'sd32768, "t5_c");
        send(-16'sd1, "t5_d");
        send(-16'sd5, "t5_e");
        step(1'b1, 16'sd1, 1'b0);   check_emit("t5_minneg", 3, 1, 1'b0);
        step(1'b0, 16'sd0, 1'b1);   check_emit("t5_flush_b", 1, 0, 1'b1);

        // reset mid-epoch discards it
        send(16'sd1, "t6_a");
        send(16'sd2, "t6_b");
        send(16'sd3, "t6_c");
        rst = 1'b1;
        step(1'b0, 16'sd0, 1'b0);
        check_quiet("t6_rst");
        rst = 1'b0;
        send(16'sd4, "t6_d");
        step(1'b1, -16'sd4, 1'b0);  check_emit("t6_after_rst", 1, 0, 1'b1);
        step(1'b0, 16'sd0, 1'b0);   check_quiet("t6_tail");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
